// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request, 11-bit frame, ACK).
// Single computerClk domain; the keyboard lines are only sampled, never clocked on.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       computerClk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2_KBCLK,
    input  logic       PS2_KBDAT,
    output logic       kbclk_drive_low,
    output logic       kbdat_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] INHIBIT  = 3'd1;
    localparam logic [2:0] REQ      = 3'd2;
    localparam logic [2:0] SEND     = 3'd3;
    localparam logic [2:0] ACK      = 3'd4;
    localparam logic [2:0] WAIT_REL = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          clk_drv_q, clk_drv_d;
    logic          dat_drv_q, dat_drv_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          to_q, to_d;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall;
    logic timed_out;
    logic accept;

    // Syncs reset high so an idle bus does not look like a falling edge.
    always_ff @(posedge computerClk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= PS2_KBCLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= PS2_KBDAT;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall      = clk_prev_q & ~clk_s2_q;
    assign timed_out = (cnt_q == TO_LAST);
    assign tx_ready  = (state_q == IDLE);
    assign accept    = tx_valid & tx_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        data_d    = data_q;
        par_d     = par_q;
        clk_drv_d = clk_drv_q;
        dat_drv_d = dat_drv_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        to_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                clk_drv_d = 1'b0;
                dat_drv_d = 1'b0;
                if (accept) begin
                    data_d    = tx_data;
                    par_d     = ~^tx_data;
                    cnt_d     = '0;
                    bitcnt_d  = '0;
                    clk_drv_d = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == INH_LAST) begin
                    dat_drv_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                clk_drv_d = 1'b0;
                cnt_d     = '0;
                bitcnt_d  = '0;
                state_d   = SEND;
            end
            SEND, ACK, WAIT_REL: begin
                cnt_d = cnt_q + CW'(1);
                if (timed_out) begin
                    clk_drv_d = 1'b0;
                    dat_drv_d = 1'b0;
                    to_d      = 1'b1;
                    state_d   = IDLE;
                end else if (state_q == SEND) begin
                    if (fall) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q < 4'd8) begin
                            dat_drv_d = ~data_q[bitcnt_q[2:0]];
                        end else if (bitcnt_q == 4'd8) begin
                            dat_drv_d = ~par_q;
                        end else begin
                            dat_drv_d = 1'b0;
                            state_d   = ACK;
                        end
                    end
                end else if (state_q == ACK) begin
                    if (fall) begin
                        if (dat_s2_q) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_REL;
                        end
                    end
                end else begin
                    if (clk_s2_q && dat_s2_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                clk_drv_d = 1'b0;
                dat_drv_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge computerClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            clk_drv_q <= 1'b0;
            dat_drv_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            clk_drv_q <= clk_drv_d;
            dat_drv_q <= dat_drv_d;
            done_q    <= done_d;
            err_q     <= err_d;
            to_q      <= to_d;
        end
    end

    assign kbclk_drive_low = clk_drv_q;
    assign kbdat_drive_low = dat_drv_q;
    assign busy            = (state_q != IDLE);
    assign tx_done         = done_q;
    assign tx_ack_err      = err_q;
    assign tx_timeout      = to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple keyboard model.
// Expected frame bits, parities and latencies are hand-computed constants.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       PS2_KBCLK, PS2_KBDAT;
    logic       kbclk_drive_low, kbdat_drive_low;
    logic       busy, tx_done, tx_ack_err, tx_timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int send_cyc = 0;
    int done_cnt = 0, err_cnt = 0, to_cnt = 0;

    assign PS2_KBCLK = ~(kbclk_drive_low | dev_clk_low);
    assign PS2_KBDAT = ~(kbdat_drive_low | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .computerClk(clk), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .PS2_KBCLK(PS2_KBCLK), .PS2_KBDAT(PS2_KBDAT),
        .kbclk_drive_low(kbclk_drive_low), .kbdat_drive_low(kbdat_drive_low),
        .busy(busy), .tx_done(tx_done), .tx_ack_err(tx_ack_err),
        .tx_timeout(tx_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done)    done_cnt <= done_cnt + 1;
        if (tx_ack_err) err_cnt  <= err_cnt + 1;
        if (tx_timeout) to_cnt   <= to_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        chk("ready_before_send", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    // Keyboard model: waits for the request, then clocks nedges bits in.
    task automatic dev_xfer(input int nedges, input bit ack,
                            output logic [9:0] bits);
        int ok;
        ok = 0;
        bits = '0;
        for (int i = 0; i < 400 && ok == 0; i++) begin
            @(negedge clk);
            if (PS2_KBCLK === 1'b1 && PS2_KBDAT === 1'b0) begin
                ok = 1;
                send_cyc = cyc;
            end
        end
        chk("request_seen", ok, 1);
        if (ok == 0) return;
        repeat (HALF) @(negedge clk);
        for (int e = 1; e <= nedges && e <= 10; e++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            bits[e-1] = PS2_KBDAT;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        if (nedges >= 11) begin
            dev_dat_low = ack;
            repeat (4) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic full_frame(input logic [7:0] d, input logic par);
        logic [9:0] bits;
        int d0, e0, t0;
        d0 = done_cnt; e0 = err_cnt; t0 = to_cnt;
        send_byte(d);
        dev_xfer(11, 1'b1, bits);
        repeat (20) @(negedge clk);
        chk("frame_data", bits[7:0], d);
        chk("frame_parity", bits[8], par);
        chk("frame_odd", ^bits[8:0], 1);
        chk("frame_stop", bits[9], 1);
        chk("done_once", done_cnt - d0, 1);
        chk("no_err", (err_cnt - e0) + (to_cnt - t0), 0);
        chk("idle_lines", {kbclk_drive_low, kbdat_drive_low, busy}, 0);
        chk("idle_ready", tx_ready, 1);
    endtask

    initial begin
        logic [9:0] bits;
        int n, k, found, e0, d0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs",
            {kbclk_drive_low, kbdat_drive_low, busy,
             tx_done, tx_ack_err, tx_timeout}, 0);
        chk("rst_ready", tx_ready, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Inhibit length, request cycle, tx_valid ignored while busy
        send_byte(8'h3C);
        chk("busy_after_accept", busy, 1);
        n = 0;
        while (kbclk_drive_low && !kbdat_drive_low && n < 1000) begin
            n++;
            if (n == 3) begin tx_valid = 1'b1; tx_data = 8'h55; end
            if (n == 4) begin tx_valid = 1'b0; tx_data = 8'h00; end
            @(negedge clk);
        end
        chk("inhibit_len", n, INH);
        chk("req_both_low", {kbclk_drive_low, kbdat_drive_low}, 2'b11);
        @(negedge clk);
        chk("send_entry", {kbclk_drive_low, kbdat_drive_low}, 2'b01);
        d0 = done_cnt;
        dev_xfer(11, 1'b1, bits);
        repeat (20) @(negedge clk);
        chk("t5_data", bits[7:0], 8'h3C);
        chk("t5_parity", bits[8], 1);
        chk("t5_done", done_cnt - d0, 1);
        k = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (kbclk_drive_low || busy) k++;
        end
        chk("no_second_frame", k, 0);

        // Command bytes with known parity
        full_frame(8'hED, 1'b1);
        full_frame(8'h07, 1'b0);
        full_frame(8'hFF, 1'b1);

        // No ACK from device
        e0 = err_cnt; d0 = done_cnt;
        send_byte(8'hA5);
        dev_xfer(11, 1'b0, bits);
        repeat (5) @(negedge clk);
        chk("noack_bits", bits, 10'b11_1010_0101);
        chk("noack_err", err_cnt - e0, 1);
        chk("noack_no_done", done_cnt - d0, 0);
        chk("noack_lines", {kbclk_drive_low, kbdat_drive_low}, 0);
        chk("noack_ready", tx_ready, 1);

        // Device stops clocking after edge 4
        e0 = to_cnt;
        send_byte(8'h12);
        dev_xfer(4, 1'b1, bits);
        chk("to_bits", bits[3:0], 4'h2);
        found = 0;
        for (int i = 0; i < TO + 500 && found == 0; i++) begin
            @(negedge clk);
            if (tx_timeout) found = cyc;
        end
        chk("to_seen", found != 0, 1);
        chk("to_latency", found - send_cyc, TO);
        chk("to_lines", {kbclk_drive_low, kbdat_drive_low, busy}, 0);
        @(negedge clk);
        chk("to_pulse_count", to_cnt - e0, 1);
        chk("to_ready", tx_ready, 1);

        // Async reset while the device holds edge 6 low
        send_byte(8'h07);
        dev_xfer(5, 1'b1, bits);
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_rst_dat", kbdat_drive_low, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_lines", {kbclk_drive_low, kbdat_drive_low}, 0);
        chk("async_rst_busy", busy, 0);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        full_frame(8'hF4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
